// File: rtl/sync_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_core
// Purpose  : Single-clock FIFO with registered read port, fill-level code and
//            sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_core #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic [2:0]            fifo_status,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int            c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);
   localparam logic [c_AW:0] c_Q1   = (c_AW+1)'(DEPTH / 4);
   localparam logic [c_AW:0] c_Q2   = (c_AW+1)'(DEPTH / 2);
   localparam logic [c_AW:0] c_Q3   = (c_AW+1)'((3 * DEPTH) / 4);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]       r_wr_ptr;
   logic [c_AW-1:0]       r_rd_ptr;
   logic [c_AW:0]         r_count;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_valid;
   logic                  r_overflow;
   logic                  r_underflow;
   logic [2:0]            w_status;
   logic                  w_wr_acc;
   logic                  w_rd_acc;

   // Acceptance is judged on the pre-edge count, so full+both pops only and
   // empty+both pushes only; nothing is accepted while reset is asserted.
   assign w_wr_acc = rst_n && wr_en && (r_count != c_FULL);
   assign w_rd_acc = rst_n && rd_en && (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + 1'b1;
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (wr_en && !w_wr_acc) begin
            r_overflow <= 1'b1;
         end
         if (rd_en && !w_rd_acc) begin
            r_underflow <= 1'b1;
         end
      end
   end

   always_comb begin
      w_status = 3'd0;
      if (r_count == '0) begin
         w_status = 3'd0;
      end else if (r_count <= c_Q1) begin
         w_status = 3'd1;
      end else if (r_count <= c_Q2) begin
         w_status = 3'd2;
      end else if (r_count <= c_Q3) begin
         w_status = 3'd3;
      end else if (r_count != c_FULL) begin
         w_status = 3'd4;
      end else begin
         w_status = 3'd5;
      end
   end

   assign rd_data     = r_rd_data;
   assign rd_valid    = r_rd_valid;
   assign fifo_status = w_status;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_core
// Purpose  : Self-checking bench for sync_fifo_core against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_core;

   localparam int c_DW    = 32;
   localparam int c_DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            wr_en = 1'b0;
   logic            rd_en = 1'b0;
   logic [c_DW-1:0] write_data = '0;
   logic [c_DW-1:0] rd_data;
   logic            rd_valid;
   logic [2:0]      fifo_status;
   logic            overflow;
   logic            underflow;

   logic [c_DW-1:0] q[$];
   logic            exp_valid = 1'b0;
   logic [c_DW-1:0] exp_data = '0;
   logic            exp_ovf = 1'b0;
   logic            exp_udf = 1'b0;
   int              n_cmp = 0;
   int              n_bad = 0;

   sync_fifo_core #(.DATA_WIDTH(c_DW), .DEPTH(c_DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .write_data (write_data),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .fifo_status(fifo_status),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Fill-level code: 0 empty, 5 full, otherwise the quarter band holding n.
   function automatic logic [2:0] status_of(input int n);
      if (n == 0)            return 3'd0;
      else if (n == c_DEPTH) return 3'd5;
      else                   return 3'(1 + (n - 1) / (c_DEPTH / 4));
   endfunction

   // Drive one clock cycle and advance the model using the pre-edge state.
   task automatic step(input logic rs, input logic w, input logic r, input logic [c_DW-1:0] d);
      int  n;
      logic rok, wok;
      rst_n = rs; wr_en = w; rd_en = r; write_data = d;
      if (!rs) begin
         q.delete();
         exp_valid = 1'b0; exp_data = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
      end else begin
         n   = q.size();
         rok = r && (n > 0);
         wok = w && (n < c_DEPTH);
         if (rok) exp_data = q.pop_front();
         exp_valid = rok;
         if (w && !wok) exp_ovf = 1'b1;
         if (r && !rok) exp_udf = 1'b1;
         if (wok) q.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b0, 1'b1, 1'b1, $urandom);
      step(1'b0, 1'b1, 1'b1, $urandom);
      n_cmp += 5;
      if (fifo_status !== 3'd0) begin n_bad++; $display("FAIL reset_status got %0d want 0", fifo_status); end
      if (rd_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_valid got %b want 0", rd_valid); end
      if (rd_data !== '0)       begin n_bad++; $display("FAIL reset_data got %h want 0", rd_data); end
      if (overflow !== 1'b0)    begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
      if (underflow !== 1'b0)   begin n_bad++; $display("FAIL reset_udf got %b want 0", underflow); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < c_DEPTH; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h11 + 32'(i));
         n_cmp++;
         if (fifo_status !== status_of(i + 1)) begin
            n_bad++; $display("FAIL fill_status[%0d] got %0d want %0d", i, fifo_status, status_of(i + 1));
         end
      end
      n_cmp++;
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_ovf got %b want 0", overflow); end
   endtask

   task automatic test_overflow();
      step(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
      n_cmp += 2;
      if (fifo_status !== 3'd5) begin n_bad++; $display("FAIL ovf_status got %0d want 5", fifo_status); end
      if (overflow !== 1'b1)    begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
   endtask

   task automatic test_full_both();
      step(1'b1, 1'b1, 1'b1, 32'hCAFE_0000);
      n_cmp += 4;
      if (rd_valid !== 1'b1)     begin n_bad++; $display("FAIL fullboth_valid got %b want 1", rd_valid); end
      if (rd_data !== 32'h11)    begin n_bad++; $display("FAIL fullboth_data got %h want 00000011", rd_data); end
      if (fifo_status !== 3'd4)  begin n_bad++; $display("FAIL fullboth_status got %0d want 4", fifo_status); end
      if (overflow !== 1'b1)     begin n_bad++; $display("FAIL fullboth_ovf got %b want 1", overflow); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < c_DEPTH - 1; i++) begin
         step(1'b1, 1'b0, 1'b1, '0);
         n_cmp += 2;
         if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d] got %b want 1", i, rd_valid); end
         if (rd_data !== 32'h12 + 32'(i)) begin
            n_bad++; $display("FAIL drain_data[%0d] got %h want %h", i, rd_data, 32'h12 + 32'(i));
         end
      end
      n_cmp++;
      if (fifo_status !== 3'd0) begin n_bad++; $display("FAIL drain_status got %0d want 0", fifo_status); end
   endtask

   task automatic test_underflow();
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b1, '0);
      n_cmp += 3;
      if (rd_valid !== 1'b0)    begin n_bad++; $display("FAIL udf_valid got %b want 0", rd_valid); end
      if (fifo_status !== 3'd0) begin n_bad++; $display("FAIL udf_status got %0d want 0", fifo_status); end
      if (underflow !== 1'b1)   begin n_bad++; $display("FAIL udf_flag got %b want 1", underflow); end
      step(1'b1, 1'b1, 1'b1, 32'hA5);
      n_cmp += 3;
      if (fifo_status !== 3'd1) begin n_bad++; $display("FAIL udf_both_status got %0d want 1", fifo_status); end
      if (rd_valid !== 1'b0)    begin n_bad++; $display("FAIL udf_both_valid got %b want 0", rd_valid); end
      if (rd_data !== '0)       begin n_bad++; $display("FAIL udf_both_hold got %h want 0", rd_data); end
      step(1'b1, 1'b0, 1'b1, '0);
      n_cmp += 2;
      if (rd_valid !== 1'b1)    begin n_bad++; $display("FAIL udf_pop_valid got %b want 1", rd_valid); end
      if (rd_data !== 32'hA5)   begin n_bad++; $display("FAIL udf_pop_data got %h want 000000a5", rd_data); end
   endtask

   task automatic test_back_to_back();
      step(1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, $urandom);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b1, 1'b1, 32'h1000 + 32'(i));
         n_cmp += 3;
         if (rd_valid !== 1'b1)     begin n_bad++; $display("FAIL b2b_valid[%0d] got %b want 1", i, rd_valid); end
         if (rd_data !== exp_data)  begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, rd_data, exp_data); end
         if (fifo_status !== 3'd2)  begin n_bad++; $display("FAIL b2b_status[%0d] got %0d want 2", i, fifo_status); end
      end
   endtask

   task automatic test_mid_reset();
      logic [c_DW-1:0] first;
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b1, '0);
      for (int i = 0; i < c_DEPTH + 1; i++) step(1'b1, 1'b1, 1'b0, $urandom | 32'h1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, '0);
      step(1'b0, 1'b1, 1'b1, $urandom);
      n_cmp += 5;
      if (fifo_status !== 3'd0) begin n_bad++; $display("FAIL midrst_status got %0d want 0", fifo_status); end
      if (rd_valid !== 1'b0)    begin n_bad++; $display("FAIL midrst_valid got %b want 0", rd_valid); end
      if (rd_data !== '0)       begin n_bad++; $display("FAIL midrst_data got %h want 0", rd_data); end
      if (overflow !== 1'b0)    begin n_bad++; $display("FAIL midrst_ovf got %b want 0", overflow); end
      if (underflow !== 1'b0)   begin n_bad++; $display("FAIL midrst_udf got %b want 0", underflow); end
      first = $urandom;
      step(1'b1, 1'b1, 1'b0, first);
      step(1'b1, 1'b1, 1'b0, $urandom);
      step(1'b1, 1'b1, 1'b0, $urandom);
      wr_en = 1'b0;
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0, '0);
      n_cmp++;
      if (fifo_status !== status_of(3)) begin n_bad++; $display("FAIL asyncpulse_status got %0d want %0d", fifo_status, status_of(3)); end
      step(1'b1, 1'b0, 1'b1, '0);
      n_cmp++;
      if (rd_data !== first) begin n_bad++; $display("FAIL asyncpulse_data got %h want %h", rd_data, first); end
   endtask

   task automatic test_random();
      logic rs, w, r;
      int   pw;
      step(1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 600; i++) begin
         pw = ((i / 100) % 2 == 0) ? 70 : 30;
         rs = ($urandom_range(0, 99) != 0);
         w  = ($urandom_range(0, 99) < pw);
         r  = ($urandom_range(0, 99) < (100 - pw));
         step(rs, w, r, $urandom);
         n_cmp += 5;
         if (rd_valid !== exp_valid) begin n_bad++; $display("FAIL rnd_valid[%0d] got %b want %b", i, rd_valid, exp_valid); end
         if (rd_data !== exp_data)   begin n_bad++; $display("FAIL rnd_data[%0d] got %h want %h", i, rd_data, exp_data); end
         if (fifo_status !== status_of(q.size())) begin
            n_bad++; $display("FAIL rnd_status[%0d] got %0d want %0d", i, fifo_status, status_of(q.size()));
         end
         if (overflow !== exp_ovf)   begin n_bad++; $display("FAIL rnd_ovf[%0d] got %b want %b", i, overflow, exp_ovf); end
         if (underflow !== exp_udf)  begin n_bad++; $display("FAIL rnd_udf[%0d] got %b want %b", i, underflow, exp_udf); end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_full_both();
      test_drain();
      test_underflow();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
